// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the DMEM core/host port arbiter.
package dmem_arb_pkg;

    typedef enum logic [0:0] {
        CORE_PRI   = 1'b0,
        HOST_FORCE = 1'b1
    } arb_state_e;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    localparam int unsigned STARVE_CNT_W = 8;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating host-starvation counter; o_hit flags that the next count reaches LIMIT.
module dmem_arb_starve_cnt
    import dmem_arb_pkg::*;
#(
    parameter int unsigned LIMIT = 8,
    parameter int unsigned W     = STARVE_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_hit
);

    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc && (r_cnt != LIM)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Looking at the next value lets the force state be live in the very next cycle.
    assign o_hit = (w_cnt_nxt == LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core/host arbiter for a single-ported synchronous DMEM with 1-cycle read return.
// Optional starvation guard enabled by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  core_req,
    input  logic [DATA_W/8-1:0]   core_we,
    input  logic [ADDR_W-1:0]     core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    output logic                  core_stall,
    output logic                  core_rvalid,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  host_req,
    input  logic [DATA_W/8-1:0]   host_we,
    input  logic [ADDR_W-1:0]     host_addr,
    input  logic [DATA_W-1:0]     host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [DATA_W-1:0]     host_rdata,
    output logic                  mem_en,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 255)) begin : g_bad_limit
        $error("dmem_port_arbiter: STARVE_LIMIT must be in 1..255");
    end

    logic w_host_first;
    logic w_core_win;
    logic w_host_win;
    logic w_rd_grant;
    logic r_rd_pend;
    logic r_owner;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       w_starve_hit;

    dmem_arb_starve_cnt #(
        .LIMIT (STARVE_LIMIT),
        .W     (STARVE_CNT_W)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (host_req & w_core_win),
        .i_clr (w_host_win | ~host_req),
        .o_hit (w_starve_hit)
    );

    assign w_host_first = (r_state == HOST_FORCE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CORE_PRI:   if (w_starve_hit) w_state_nxt = HOST_FORCE;
            HOST_FORCE: if (w_host_win || !host_req) w_state_nxt = CORE_PRI;
            default:    w_state_nxt = CORE_PRI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CORE_PRI;
        end else begin
            r_state <= w_state_nxt;
        end
    end
`else
    assign w_host_first = 1'b0;
`endif

    // Grants are suppressed while reset is held so every output except core_stall reads 0.
    always_comb begin
        w_core_win = 1'b0;
        w_host_win = 1'b0;
        if (rst_n) begin
            if (w_host_first) begin
                if (host_req)      w_host_win = 1'b1;
                else if (core_req) w_core_win = 1'b1;
            end else begin
                if (core_req)      w_core_win = 1'b1;
                else if (host_req) w_host_win = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_core_win) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
        end else if (w_host_win) begin
            mem_en    = 1'b1;
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    assign core_stall = core_req & ~w_core_win;
    assign host_gnt   = w_host_win;
    assign w_rd_grant = mem_en & (mem_we == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pend <= 1'b0;
            r_owner   <= OWN_CORE;
        end else begin
            r_rd_pend <= w_rd_grant;
            if (w_rd_grant) begin
                r_owner <= w_host_win ? OWN_HOST : OWN_CORE;
            end
        end
    end

    assign core_rvalid = r_rd_pend & (r_owner == OWN_CORE);
    assign host_rvalid = r_rd_pend & (r_owner == OWN_HOST);
    assign core_rdata  = core_rvalid ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural single-port RAM.
// Guard-specific expectations follow DMEM_ARB_STARVE_GUARD_EN.
module tb_dmem_port_arbiter;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 32;
    localparam int unsigned LIMIT = 8;

    logic          clk;
    logic          rst_n;
    logic          core_req;
    logic [3:0]    core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_stall;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;
    logic          host_req;
    logic [3:0]    host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] core_q[$];
    logic [31:0] host_q[$];

    dmem_port_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_stall  (core_stall),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input logic [AW-1:0] a);
        if (a == 14'h010) return 32'hDEADBEEF;
        return {16'hC0DE, 2'b00, a};
    endfunction

    // Behavioural RAM: read-before-write, data one cycle after mem_en.
    bit [31:0] ram    [0:(1<<AW)-1];
    bit        ram_wr [0:(1<<AW)-1];
    always @(posedge clk) begin
        logic [31:0] rd;
        logic [31:0] nw;
        if (mem_en) begin
            rd = ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            mem_rdata <= rd;
            if (mem_we != 4'b0000) begin
                nw = rd;
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) nw[8*b +: 8] = mem_wdata[8*b +: 8];
                ram[mem_addr]    <= nw;
                ram_wr[mem_addr] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic check_grant(input string tag, input logic e_stall, input logic e_gnt,
                               input logic e_en, input logic [3:0] e_we,
                               input logic [AW-1:0] e_addr, input logic [31:0] e_wd);
        chk({tag, "_stall"}, 32'(core_stall), 32'(e_stall));
        chk({tag, "_gnt"},   32'(host_gnt),   32'(e_gnt));
        chk({tag, "_en"},    32'(mem_en),     32'(e_en));
        chk({tag, "_we"},    32'(mem_we),     32'(e_we));
        chk({tag, "_addr"},  32'(mem_addr),   32'(e_addr));
        chk({tag, "_wdata"}, mem_wdata,       e_wd);
    endtask

    task automatic cyc(input logic cr, input logic [3:0] cw, input logic [AW-1:0] ca,
                       input logic [31:0] cd, input logic hr, input logic [3:0] hw,
                       input logic [AW-1:0] ha, input logic [31:0] hd);
        @(posedge clk);
        #1;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, '0, '0, 1'b0, 4'h0, '0, '0);
    endtask

    // Response monitor: every rvalid pops the owner's queue; rdata must be 0 otherwise.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (core_rvalid === 1'b1) begin
                if (core_q.size() == 0) chk("core_rvalid_spurious", 32'(core_rvalid), 32'd0);
                else begin
                    e = core_q.pop_front();
                    chk("core_rdata", core_rdata, e);
                end
            end else chk("core_rdata_idle", core_rdata, 32'd0);
            if (host_rvalid === 1'b1) begin
                if (host_q.size() == 0) chk("host_rvalid_spurious", 32'(host_rvalid), 32'd0);
                else begin
                    e = host_q.pop_front();
                    chk("host_rdata", host_rdata, e);
                end
            end else chk("host_rdata_idle", host_rdata, 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    logic [AW-1:0] ca_tab [4];
    logic [AW-1:0] ha_tab [4];

    initial begin
        ca_tab = '{14'h100, 14'h101, 14'h102, 14'h103};
        ha_tab = '{14'h200, 14'h201, 14'h202, 14'h203};
        rst_n = 1'b1;
        core_req = 1'b0; core_we = '0; core_addr = '0; core_wdata = '0;
        host_req = 1'b0; host_we = '0; host_addr = '0; host_wdata = '0;
        #1 rst_n = 1'b0;

        // Reset: all outputs quiet, stall follows core_req
        @(negedge clk);
        check_grant("rst_idle", 0, 0, 0, 4'h0, '0, '0);
        chk("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        core_req = 1'b1; core_addr = 14'h3; host_req = 1'b1;
        #1;
        check_grant("rst_req", 1, 0, 0, 4'h0, '0, '0);
        core_req = 1'b0; core_addr = '0; host_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Idle, then core read of 0x010
        idle();
        check_grant("idle", 0, 0, 0, 4'h0, '0, '0);
        cyc(1, 4'h0, 14'h010, '0, 0, 4'h0, '0, '0);
        check_grant("t1_rd", 0, 0, 1, 4'h0, 14'h010, '0);
        core_q.push_back(32'hDEADBEEF);
        idle();
        check_grant("t1_after", 0, 0, 0, 4'h0, '0, '0);

        // Simultaneous writes: core wins, host granted once core drops
        for (int i = 0; i < 2; i++) begin
            cyc(1, 4'hF, 14'h020, 32'h11112222, 1, 4'hF, 14'h030, 32'h33334444);
            check_grant("t2_core_wr", 0, 0, 1, 4'hF, 14'h020, 32'h11112222);
        end
        cyc(0, 4'h0, '0, '0, 1, 4'hF, 14'h030, 32'h33334444);
        check_grant("t2_host_wr", 0, 1, 1, 4'hF, 14'h030, 32'h33334444);
        idle();
        cyc(1, 4'h0, 14'h020, '0, 0, 4'h0, '0, '0);
        check_grant("t2_core_rb", 0, 0, 1, 4'h0, 14'h020, '0);
        core_q.push_back(32'h11112222);
        cyc(0, 4'h0, '0, '0, 1, 4'h0, 14'h030, '0);
        check_grant("t2_host_rb", 0, 1, 1, 4'h0, 14'h030, '0);
        host_q.push_back(32'h33334444);
        idle();

        // Core held high with a host read pending
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int i = 1; i <= int'(LIMIT) + 1; i++) begin
            cyc(1, 4'h0, 14'h040, '0, 1, 4'h0, 14'h050, '0);
            if (i <= int'(LIMIT)) begin
                check_grant("t3_core", 0, 0, 1, 4'h0, 14'h040, '0);
                core_q.push_back(init_val(14'h040));
            end else begin
                check_grant("t3_force", 1, 1, 1, 4'h0, 14'h050, '0);
                host_q.push_back(init_val(14'h050));
            end
        end
        cyc(1, 4'h0, 14'h040, '0, 0, 4'h0, '0, '0);
        check_grant("t3_resume", 0, 0, 1, 4'h0, 14'h040, '0);
        core_q.push_back(init_val(14'h040));
`else
        for (int i = 1; i <= 100; i++) begin
            cyc(1, 4'h0, 14'h040, '0, 1, 4'h0, 14'h050, '0);
            check_grant("t3_strict", 0, 0, 1, 4'h0, 14'h040, '0);
            core_q.push_back(init_val(14'h040));
        end
        cyc(0, 4'h0, '0, '0, 1, 4'h0, 14'h050, '0);
        check_grant("t3_host_late", 0, 1, 1, 4'h0, 14'h050, '0);
        host_q.push_back(init_val(14'h050));
`endif
        idle();

        // Alternating core/host reads back-to-back
        for (int i = 0; i < 4; i++) begin
            cyc(1, 4'h0, ca_tab[i], '0, 0, 4'h0, '0, '0);
            check_grant("t5_core", 0, 0, 1, 4'h0, ca_tab[i], '0);
            core_q.push_back(init_val(ca_tab[i]));
            cyc(0, 4'h0, '0, '0, 1, 4'h0, ha_tab[i], '0);
            check_grant("t5_host", 0, 1, 1, 4'h0, ha_tab[i], '0);
            host_q.push_back(init_val(ha_tab[i]));
        end
        cyc(1, 4'h0, 14'h110, '0, 1, 4'h0, 14'h210, '0);
        check_grant("t5_both", 0, 0, 1, 4'h0, 14'h110, '0);
        core_q.push_back(init_val(14'h110));
        cyc(0, 4'h0, '0, '0, 1, 4'h0, 14'h210, '0);
        check_grant("t5_host_next", 0, 1, 1, 4'h0, 14'h210, '0);
        host_q.push_back(init_val(14'h210));
        cyc(1, 4'h0, 14'h111, '0, 0, 4'h0, '0, '0);
        check_grant("t5_core_next", 0, 0, 1, 4'h0, 14'h111, '0);
        core_q.push_back(init_val(14'h111));
        idle();

        // Build up host wait, then reset right after a granted core read
        for (int i = 0; i < 5; i++) begin
            cyc(1, 4'h0, 14'h070, '0, 1, 4'h0, 14'h071, '0);
            check_grant("t6_pre", 0, 0, 1, 4'h0, 14'h070, '0);
            core_q.push_back(init_val(14'h070));
        end
        cyc(1, 4'h0, 14'h060, '0, 1, 4'h0, 14'h071, '0);
        check_grant("t6_rd", 0, 0, 1, 4'h0, 14'h060, '0);
        #2;
        rst_n = 1'b0;
        core_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        chk("t6_core_rvalid_dropped", 32'(core_rvalid), 32'd0);
        chk("t6_host_rvalid", 32'(host_rvalid), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle();
        chk("t6_post_core_rvalid", 32'(core_rvalid), 32'd0);
        for (int i = 1; i <= int'(LIMIT) + 1; i++) begin
            cyc(1, 4'h0, 14'h070, '0, 1, 4'h0, 14'h071, '0);
`ifdef DMEM_ARB_STARVE_GUARD_EN
            if (i <= int'(LIMIT)) begin
                check_grant("t6_post_core", 0, 0, 1, 4'h0, 14'h070, '0);
                core_q.push_back(init_val(14'h070));
            end else begin
                check_grant("t6_post_force", 1, 1, 1, 4'h0, 14'h071, '0);
                host_q.push_back(init_val(14'h071));
            end
`else
            check_grant("t6_post_core", 0, 0, 1, 4'h0, 14'h070, '0);
            core_q.push_back(init_val(14'h070));
`endif
        end
`ifndef DMEM_ARB_STARVE_GUARD_EN
        cyc(0, 4'h0, '0, '0, 1, 4'h0, 14'h071, '0);
        check_grant("t6_post_host", 0, 1, 1, 4'h0, 14'h071, '0);
        host_q.push_back(init_val(14'h071));
`endif
        idle();
        idle();
        idle();
        chk("core_q_drained", 32'(core_q.size()), 32'd0);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
